// File: rtl/data_io_pkg.sv
// rtl/data_io_pkg.sv - shared types and constants for the SPI upload block
//
// Purpose: frame-decoder state enum, default command bytes, session
// argument bytes and the byte sent when the prefetch buffer is empty.
// Ports: none (package).
package data_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_START_ARG = 3'd2,
        ST_INDEX_ARG = 3'd3,
        ST_DATA      = 3'd4,
        ST_IGNORE    = 3'd5
    } state_t;

    localparam logic [7:0] CMD_START_DEF = 8'h58;
    localparam logic [7:0] CMD_DATA_DEF  = 8'h5A;
    localparam logic [7:0] ARG_START     = 8'hFF;
    localparam logic [7:0] ARG_END       = 8'h00;
    localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

endpackage

// File: rtl/data_io_upload_if.sv
// rtl/data_io_upload_if.sv - core memory read bus used by the upload block
//
// Purpose: groups the upload session outputs and the read request /
// acknowledge handshake toward core memory.
// Ports (signals):
//   ioctl_upload  session open          ioctl_index  file index
//   ioctl_addr    read byte address     ioctl_rd     read request (held)
//   ioctl_ack     one-cycle ack         ioctl_din    read data, valid with ack
// Modports: master = upload block, slave = core memory.
interface data_io_upload_if #(
    parameter int ADDR_W = 25
) ();

    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic [ADDR_W-1:0] ioctl_addr;
    logic              ioctl_rd;
    logic              ioctl_ack;
    logic [7:0]        ioctl_din;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_addr,
        output ioctl_rd,
        input  ioctl_ack,
        input  ioctl_din
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_addr,
        input  ioctl_rd,
        output ioctl_ack,
        output ioctl_din
    );

endinterface

// File: rtl/data_io_upload_spi_sync_edge.sv
// rtl/data_io_upload_spi_sync_edge.sv - SPI pin synchronizers and SCK edge detect
//
// Purpose: brings SCK, SS and DI into the clk domain through two flops each
// and flags rising/falling SCK edges. All three paths have equal depth so DI
// is aligned with the SCK edge it belongs to.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sck, ss_n, di       raw SPI pins
//   sck_rise, sck_fall  one-cycle edge strobes on synchronized SCK
//   ss_n_s, di_s        synchronized select and data
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic ss_n,
    input  logic di,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_n_s,
    output logic di_s
);

    logic [1:0] sck_m;
    logic [1:0] ss_m;
    logic [1:0] di_m;
    logic       sck_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_m <= 2'b00;
            ss_m  <= 2'b11;
            di_m  <= 2'b00;
            sck_d <= 1'b0;
        end else begin
            sck_m <= {sck_m[0], sck};
            ss_m  <= {ss_m[0], ss_n};
            di_m  <= {di_m[0], di};
            sck_d <= sck_m[1];
        end
    end

    assign sck_rise = sck_m[1] & ~sck_d;
    assign sck_fall = ~sck_m[1] & sck_d;
    assign ss_n_s   = ss_m[1];
    assign di_s     = di_m[1];

endmodule

// File: rtl/data_io_upload.sv
// rtl/data_io_upload.sv - SPI-driven upload of core memory to the host
//
// Purpose: decodes host SPI frames (mode 0, MSB first) to open/close an
// upload session and streams core memory bytes out on spi_do, keeping one
// byte prefetched ahead.
// Ports:
//   clk_sys, reset               clock, synchronous active-high reset
//   SPI_SCK, SPI_SS2, SPI_DI     host SPI pins (asynchronous)
//   spi_do, spi_do_oe            serial data to host and its output enable
//   ioctl                        memory read bus (master modport)
//   underrun                     sticky: a byte was sent before its data arrived
module data_io_upload
    import data_io_pkg::*;
#(
    parameter int         ADDR_W    = 25,
    parameter logic [7:0] CMD_START = CMD_START_DEF,
    parameter logic [7:0] CMD_DATA  = CMD_DATA_DEF
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    SPI_SCK,
    input  logic                    SPI_SS2,
    input  logic                    SPI_DI,
    output logic                    spi_do,
    output logic                    spi_do_oe,
    data_io_upload_if.master        ioctl,
    output logic                    underrun
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic sck_rise;
    logic sck_fall;
    logic ss_n;
    logic di;

    spi_sync_edge u_sync (
        .clk      (clk_sys),
        .reset    (reset),
        .sck      (SPI_SCK),
        .ss_n     (SPI_SS2),
        .di       (SPI_DI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_n_s   (ss_n),
        .di_s     (di)
    );

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [7:0]        tx_sr;
    logic              entry_skip;
    logic [7:0]        buf_q;
    logic              buf_valid;
    logic              upload_q;
    logic [7:0]        index_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    logic              underrun_q;

    logic data_entry;
    logic data_fall;
    logic load;
    logic shift;
    logic ack_take;
    logic start_evt;
    logic end_evt;

    assign rx_byte   = {rx_sr, di};
    assign byte_done = sck_rise && !ss_n && (state_q != ST_IDLE) && (bit_cnt == 3'd7);
    assign ack_take  = rd_q && ioctl.ioctl_ack;
    assign start_evt = (state_q == ST_START_ARG) && byte_done && (rx_byte == ARG_START);
    assign end_evt   = (state_q == ST_START_ARG) && byte_done && (rx_byte == ARG_END);

    // The fall right after the command byte belongs to the command byte; the
    // entry load has already placed the first data byte, so that fall is skipped.
    assign data_entry = (state_q == ST_CMD) && (state_d == ST_DATA);
    assign data_fall  = sck_fall && !ss_n && (state_q == ST_DATA) && !entry_skip;
    assign load       = data_entry || (data_fall && (bit_cnt == 3'd0));
    assign shift      = data_fall && (bit_cnt != 3'd0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ss_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_START) begin
                            state_d = ST_START_ARG;
                        end else if ((rx_byte == CMD_DATA) && upload_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_START_ARG: begin
                    if (byte_done) begin
                        state_d = (rx_byte == ARG_START) ? ST_INDEX_ARG : ST_IGNORE;
                    end
                end
                ST_INDEX_ARG: begin
                    if (byte_done) begin
                        state_d = ST_IGNORE;
                    end
                end
                ST_DATA:   state_d = ST_DATA;
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        spi_do_oe = 1'b0;
        spi_do    = 1'b0;
        if ((state_q == ST_DATA) && !ss_n) begin
            spi_do_oe = 1'b1;
            spi_do    = tx_sr[7];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_sr      <= 7'd0;
            tx_sr      <= 8'd0;
            entry_skip <= 1'b0;
            buf_q      <= 8'd0;
            buf_valid  <= 1'b0;
            upload_q   <= 1'b0;
            index_q    <= 8'd0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte[6:0];
            end

            if (data_entry) begin
                entry_skip <= 1'b1;
            end else if (sck_fall && (state_q == ST_DATA)) begin
                entry_skip <= 1'b0;
            end

            // An ack arriving together with a load goes straight to the
            // shifter, so the buffer stays empty and no underrun is flagged.
            if (load) begin
                if (buf_valid) begin
                    tx_sr <= buf_q;
                end else if (ack_take) begin
                    tx_sr <= ioctl.ioctl_din;
                end else begin
                    tx_sr      <= UNDERRUN_FILL;
                    underrun_q <= 1'b1;
                end
            end else if (shift) begin
                tx_sr <= {tx_sr[6:0], 1'b1};
            end

            if (load) begin
                buf_valid <= 1'b0;
            end else if (ack_take) begin
                buf_q     <= ioctl.ioctl_din;
                buf_valid <= 1'b1;
            end

            if (ack_take) begin
                rd_q   <= 1'b0;
                addr_q <= addr_q + ADDR_ONE;
            end else if (upload_q && !buf_valid && !rd_q) begin
                rd_q <= 1'b1;
            end

            if ((state_q == ST_INDEX_ARG) && byte_done) begin
                index_q <= rx_byte;
            end

            // A new session discards any stale prefetched byte.
            if (start_evt) begin
                upload_q   <= 1'b1;
                addr_q     <= '0;
                buf_valid  <= 1'b0;
                underrun_q <= 1'b0;
            end
            if (end_evt) begin
                upload_q <= 1'b0;
            end
        end
    end

    assign ioctl.ioctl_upload = upload_q;
    assign ioctl.ioctl_index  = index_q;
    assign ioctl.ioctl_addr   = addr_q;
    assign ioctl.ioctl_rd     = rd_q;
    assign underrun           = underrun_q;

endmodule

// File: tb/tb_data_io_upload.sv
// tb/tb_data_io_upload.sv - self-checking bench for data_io_upload
module tb_data_io_upload;

    localparam int ADDR_W = 25;
    localparam int H      = 80;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic SPI_SCK = 1'b0;
    logic SPI_SS2 = 1'b1;
    logic SPI_DI  = 1'b0;
    logic spi_do;
    logic spi_do_oe;
    logic underrun;

    data_io_upload_if #(.ADDR_W(ADDR_W)) ioctl ();

    data_io_upload #(.ADDR_W(ADDR_W)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .SPI_SCK   (SPI_SCK),
        .SPI_SS2   (SPI_SS2),
        .SPI_DI    (SPI_DI),
        .spi_do    (spi_do),
        .spi_do_oe (spi_do_oe),
        .ioctl     (ioctl),
        .underrun  (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] mem [256];
    logic [7:0] tx [8];
    logic [7:0] rx [8];
    logic       oe_seen;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         ack_delay = 2;
    logic       resp_en = 1'b0;
    logic       manual_ack = 1'b0;
    logic [7:0] manual_din = 8'd0;

    // Core memory model: acknowledges a held read after ack_delay cycles.
    initial begin
        int cnt;
        cnt = 0;
        ioctl.ioctl_ack = 1'b0;
        ioctl.ioctl_din = 8'd0;
        forever begin
            @(posedge clk_sys);
            #1;
            ioctl.ioctl_ack = 1'b0;
            if (manual_ack) begin
                ioctl.ioctl_ack = 1'b1;
                ioctl.ioctl_din = manual_din;
                manual_ack = 1'b0;
                cnt = 0;
            end else if (resp_en && ioctl.ioctl_rd) begin
                if (cnt >= ack_delay) begin
                    ioctl.ioctl_ack = 1'b1;
                    ioctl.ioctl_din = mem[ioctl.ioctl_addr[7:0]];
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Mode-0 host: DI changes with SCK low, MISO sampled at the SCK rise.
    // SS2 rises while SCK is still high after the last clocked bit.
    task automatic spi_frame(input int nbits);
        for (int k = 0; k < 8; k++) rx[k] = 8'd0;
        oe_seen = 1'b0;
        SPI_SS2 = 1'b0;
        #(H);
        for (int i = 0; i < nbits; i++) begin
            SPI_SCK = 1'b0;
            SPI_DI  = tx[i/8][7-(i%8)];
            #(H);
            SPI_SCK = 1'b1;
            rx[i/8][7-(i%8)] = spi_do;
            if (spi_do_oe) oe_seen = 1'b1;
            #(H);
        end
        SPI_SS2 = 1'b1;
        #(H);
        SPI_SCK = 1'b0;
        SPI_DI  = 1'b0;
        #(4*H);
    endtask

    initial begin
        int         m_ptr;
        logic [7:0] idx;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);

        wait_clk(4);
        check("rst_upload", 32'(ioctl.ioctl_upload), 32'd0);
        check("rst_index", 32'(ioctl.ioctl_index), 32'd0);
        check("rst_addr", 32'(ioctl.ioctl_addr), 32'd0);
        check("rst_rd", 32'(ioctl.ioctl_rd), 32'd0);
        check("rst_do", 32'(spi_do), 32'd0);
        check("rst_oe", 32'(spi_do_oe), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        wait_clk(4);

        // Session start with memory held off: prefetch visible at address 0.
        resp_en = 1'b0;
        idx = 8'($urandom);
        tx[0] = 8'h58; tx[1] = 8'hFF; tx[2] = idx;
        spi_frame(24);
        wait_clk(4);
        check("s1_upload", 32'(ioctl.ioctl_upload), 32'd1);
        check("s1_index", 32'(ioctl.ioctl_index), 32'(idx));
        check("s1_addr", 32'(ioctl.ioctl_addr), 32'd0);
        check("s1_rd", 32'(ioctl.ioctl_rd), 32'd1);
        check("s1_underrun", 32'(underrun), 32'd0);

        // Four-byte stream, memory answering two cycles after each request.
        resp_en = 1'b1;
        ack_delay = 2;
        wait_clk(10);
        m_ptr = 0;
        tx[0] = 8'h5A;
        for (int k = 1; k <= 4; k++) tx[k] = 8'($urandom);
        spi_frame(40);
        for (int k = 1; k <= 4; k++) begin
            check("s2_miso", 32'(rx[k]), 32'(mem[m_ptr]));
            m_ptr++;
        end
        check("s2_oe_seen", 32'(oe_seen), 32'd1);
        wait_clk(10);
        check("s2_addr", 32'(ioctl.ioctl_addr), 32'(m_ptr + 1));
        check("s2_underrun", 32'(underrun), 32'd0);
        check("s2_oe_after", 32'(spi_do_oe), 32'd0);
        check("s2_do_after", 32'(spi_do), 32'd0);

        // Frame cut after 3 bits of the first data byte: that byte is lost,
        // the next frame continues from the byte after it.
        tx[0] = 8'h5A; tx[1] = 8'($urandom);
        spi_frame(11);
        m_ptr++;
        wait_clk(10);
        tx[1] = 8'($urandom); tx[2] = 8'($urandom);
        spi_frame(24);
        check("s3_miso0", 32'(rx[1]), 32'(mem[m_ptr]));
        check("s3_miso1", 32'(rx[2]), 32'(mem[m_ptr + 1]));
        m_ptr += 2;
        wait_clk(10);
        check("s3_addr", 32'(ioctl.ioctl_addr), 32'(m_ptr + 1));

        // New session with memory 20 SCK periods slow: first byte underruns.
        ack_delay = 320;
        idx = 8'($urandom);
        tx[0] = 8'h58; tx[1] = 8'hFF; tx[2] = idx;
        spi_frame(24);
        wait_clk(2);
        tx[0] = 8'h5A; tx[1] = 8'($urandom); tx[2] = 8'($urandom);
        spi_frame(24);
        m_ptr = 1;
        check("s4_index", 32'(ioctl.ioctl_index), 32'(idx));
        check("s4_fill", 32'(rx[1]), 32'hFF);
        check("s4_late", 32'(rx[2]), 32'(mem[0]));
        check("s4_underrun", 32'(underrun), 32'd1);
        wait_clk(400);
        check("s4_addr", 32'(ioctl.ioctl_addr), 32'(m_ptr + 1));

        // Session close: a later data frame is ignored.
        ack_delay = 2;
        tx[0] = 8'h58; tx[1] = 8'h00;
        spi_frame(16);
        wait_clk(4);
        check("s5_upload", 32'(ioctl.ioctl_upload), 32'd0);
        check("s5_rd", 32'(ioctl.ioctl_rd), 32'd0);
        tx[0] = 8'h5A; tx[1] = 8'($urandom);
        spi_frame(16);
        check("s5_oe_seen", 32'(oe_seen), 32'd0);
        check("s5_miso", 32'(rx[1]), 32'd0);

        // Reset while a read is outstanding; a later ack must be ignored.
        resp_en = 1'b0;
        tx[0] = 8'h58; tx[1] = 8'hFF;
        spi_frame(16);
        wait_clk(4);
        check("s6_rd_pre", 32'(ioctl.ioctl_rd), 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check("s6_upload", 32'(ioctl.ioctl_upload), 32'd0);
        check("s6_index", 32'(ioctl.ioctl_index), 32'd0);
        check("s6_addr", 32'(ioctl.ioctl_addr), 32'd0);
        check("s6_rd", 32'(ioctl.ioctl_rd), 32'd0);
        check("s6_do", 32'(spi_do), 32'd0);
        check("s6_oe", 32'(spi_do_oe), 32'd0);
        check("s6_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        manual_din = 8'($urandom);
        manual_ack = 1'b1;
        wait_clk(4);
        check("s6_ack_rd", 32'(ioctl.ioctl_rd), 32'd0);
        check("s6_ack_addr", 32'(ioctl.ioctl_addr), 32'd0);
        check("s6_ack_upload", 32'(ioctl.ioctl_upload), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_io_upload.md
DATA_IO_UPLOAD -- requirements
Module: data_io_upload

Interface
REQ-001 Parameter ADDR_W, 25: width of ioctl_addr.
REQ-002 Parameter CMD_START, 8'h58: SPI command byte selecting upload control.
REQ-003 Parameter CMD_DATA, 8'h5A: SPI command byte selecting upload data stream.
REQ-004 Port clk_sys  in  1: single clock; all logic on its rising edge; SPI pins oversampled, clk_sys >= 6x SPI_SCK.
REQ-005 Port reset  in  1: one clock; reset is synchronous and active-high.
REQ-006 Port SPI_SCK  in  1: host SPI clock, mode 0, MSB first, asynchronous to clk_sys.
REQ-007 Port SPI_SS2  in  1: active-low frame select from host.
REQ-008 Port SPI_DI  in  1: host-to-core serial data.
REQ-009 Port spi_do  out  1: core-to-host serial data.
REQ-010 Port spi_do_oe  out  1: high while SS2 low and a CMD_DATA frame is active; top drives SPI_DO high-Z otherwise.
REQ-011 Port ioctl_upload  out  1: high while an upload session is open.
REQ-012 Port ioctl_index  out  8: file index supplied by host at session start.
REQ-013 Port ioctl_addr  out  ADDR_W: byte address of current core read request.
REQ-014 Port ioctl_rd  out  1: read request, held until ioctl_ack.
REQ-015 Port ioctl_ack  in  1: one-cycle acknowledge; ioctl_din valid in the same cycle.
REQ-016 Port ioctl_din  in  8: read data from core memory.
REQ-017 Port underrun  out  1: sticky, set when a byte had to be sent before its data arrived.

Function
REQ-018 SCK, SS2, DI pass through 2-flop synchronizers; rising/falling edges detected on synchronized SCK, total input latency 3 clk_sys.
REQ-019 SS2 falling edge clears bit counter (3 bit) and byte counter; state -> CMD.
REQ-020 States: IDLE, CMD, START_ARG, INDEX_ARG, DATA, IGNORE; SS2 high forces IDLE from any state on the next clock.
REQ-021 CMD: after 8 SCK rises, byte == CMD_START -> START_ARG; == CMD_DATA and ioctl_upload -> DATA; else -> IGNORE.
REQ-022 START_ARG byte 8'hFF: ioctl_upload<=1, ioctl_addr<=0, underrun cleared, prefetch issued; next byte -> INDEX_ARG.
REQ-023 START_ARG byte 8'h00: ioctl_upload<=0, pending request withdrawn after its ack; -> IGNORE.
REQ-024 INDEX_ARG byte latched into ioctl_index; -> IGNORE.
REQ-025 Prefetch buffer: one byte plus valid flag; ioctl_rd asserted whenever upload open, buffer empty, no request outstanding.
REQ-026 On ioctl_ack: buffer<=ioctl_din, valid<=1, ioctl_rd<=0 same edge, ioctl_addr increments by 1 (wraps at 2^ADDR_W).
REQ-027 DATA: shift register loads from buffer on the clk_sys after the SCK falling edge that ends a byte (and on DATA entry); valid<=0; spi_do = shift MSB, shifted on each SCK falling edge.
REQ-028 Load with valid=0: shift register <= 8'hFF, underrun<=1, address not advanced; late ack fills buffer for next byte.
REQ-029 Simultaneous ack and load: loaded byte is ioctl_din of that cycle, buffer stays empty, no underrun.
REQ-030 SS2 rising mid-byte: partial byte discarded, prefetched byte retained, addresses unchanged.
REQ-031 spi_do = 0 when spi_do_oe low.

Reset
REQ-032 Reset: state IDLE, counters 0, ioctl_upload 0, ioctl_index 0, ioctl_addr 0, ioctl_rd 0, buffer valid 0, spi_do 0, spi_do_oe 0, underrun 0.
REQ-033 Reset mid-request: ioctl_rd drops next edge; later ack ignored.

Structure
REQ-034 Package data_io_pkg holds state enum, CMD_START/CMD_DATA defaults, START/END argument constants.
REQ-035 One sub-module natural: spi_sync_edge (synchronizers plus SCK edge detect).

Verification
REQ-036 Frame 58 FF 03 -> ioctl_upload=1, ioctl_index=03, ioctl_addr=0, ioctl_rd asserted.
REQ-037 Memory 0x00..0x03 = A1 B2 C3 D4, ack 2 clk after rd, frame 5A + 4 dummy bytes -> MISO A1 B2 C3 D4, ioctl_addr=5, underrun=0.
REQ-038 Ack delayed 20 SCK periods -> first data byte FF, underrun=1, next byte A1.
REQ-039 SS2 raised after 3 bits of byte 2, new 5A frame -> resumes with B2.
REQ-040 Frame 58 00 -> ioctl_upload=0; following 5A frame -> spi_do_oe stays 0.
REQ-041 Reset asserted with ioctl_rd high -> all outputs at REQ-032 values next clock.
